// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings, the SRAM slave FSM state type and the byte-lane helper.
// Optional build macro AHB_SRAM_ERR_EN adds the two-cycle ERROR states (StErr1/StErr2).
package ahb_pkg;

    // HTRANS encodings
    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransBusy   = 2'b01;
    localparam logic [1:0] HtransNonseq = 2'b10;
    localparam logic [1:0] HtransSeq    = 2'b11;

    // HSIZE encodings (2-bit subset; HsizeWide is wider than the 32-bit bus)
    localparam logic [1:0] HsizeByte = 2'b00;
    localparam logic [1:0] HsizeHalf = 2'b01;
    localparam logic [1:0] HsizeWord = 2'b10;
    localparam logic [1:0] HsizeWide = 2'b11;

    // HRESP values
    localparam logic HrespOkay  = 1'b0;
    localparam logic HrespError = 1'b1;

`ifdef AHB_SRAM_ERR_EN
    typedef enum logic [2:0] {StIdle, StWait, StDone, StErr1, StErr2} state_e;
`else
    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;
`endif

    // Byte lanes touched by a transfer; low address bits below the size are ignored
    // so misaligned halfword/word requests fall back to the aligned container.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (size)
            HsizeByte: mask = 4'b0001 << addr_lo;
            HsizeHalf: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// ahb_sram_slave_if: AHB-Lite slave-side signal bundle with master and slave views.
interface ahb_sram_slave_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [1:0]  HSIZE;
    logic        HMASTLOCK;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HMASTLOCK, HREADY, HWDATA,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HMASTLOCK, HREADY, HWDATA,
        output HRDATA, HREADYOUT, HRESP
    );

endinterface

// File: rtl/ahb_sram_mem.sv
// ahb_sram_mem: 2^ADDR_W x 32-bit SRAM built from four byte-lane arrays.
// Per-lane write enables, synchronous read whose output register holds between reads.
module ahb_sram_mem #(
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [3:0]        we_i,
    input  logic [31:0]       wdata_i,
    input  logic              re_i,
    output logic [31:0]       rdata_o
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] mem_q [Depth];
        logic [7:0] rdata_q;

        // Lane write; storage is deliberately left out of reset.
        always_ff @(posedge clk_i) begin
            if (we_i[g]) begin
                mem_q[addr_i] <= wdata_i[8*g +: 8];
            end
        end

        // Lane read register; only reloads on a read so the bus sees stable data.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rdata_q <= '0;
            end else if (re_i) begin
                rdata_q <= mem_q[addr_i];
            end
        end

        assign rdata_o[8*g +: 8] = rdata_q;
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM slave with WAIT_STATES fixed wait cycles per data phase.
// Build macro AHB_SRAM_ERR_EN: out-of-range address or HSIZE=3 answers with ERROR.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned WAIT_STATES = 3
) (
    input  logic             clk,
    input  logic             rst,
    ahb_sram_slave_if.slave  bus_io
);

    localparam logic [3:0] LastCnt = 4'(WAIT_STATES - 1);

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              hreadyout_q;
    logic              write_q;
    logic [3:0]        be_q;
    logic [ADDR_W-1:0] addr_q;

    logic              bus_free;
    logic              accept;
    logic              mem_re;
    logic [3:0]        mem_we;
    logic [31:0]       mem_rdata;

    // HMASTLOCK has no meaning for a single-ported SRAM; upper address bits only
    // matter in the error-checking build.
    logic unused_bits;
    assign unused_bits = ^{bus_io.HMASTLOCK, bus_io.HADDR[31:ADDR_W+2]};

`ifdef AHB_SRAM_ERR_EN
    logic hresp_q;
    logic err_req;

    // Requests the SRAM cannot serve: address beyond the array or a >32-bit size.
    always_comb begin
        err_req = (|bus_io.HADDR[31:ADDR_W+2]) || (bus_io.HSIZE == HsizeWide);
    end
`endif

    // A new address phase may only land when no data phase is stalling the bus.
    always_comb begin
        bus_free = (state_q != StWait);
`ifdef AHB_SRAM_ERR_EN
        bus_free = bus_free && (state_q != StErr1);
`endif
        accept = bus_io.HSEL && bus_io.HREADY && bus_free &&
                 ((bus_io.HTRANS == HtransNonseq) || (bus_io.HTRANS == HtransSeq));
    end

    // Transfer sequencing; HREADYOUT/HRESP are driven straight from these flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            hreadyout_q <= 1'b1;
            write_q     <= 1'b0;
            be_q        <= '0;
            addr_q      <= '0;
`ifdef AHB_SRAM_ERR_EN
            hresp_q     <= HrespOkay;
`endif
        end else begin
            unique case (state_q)
                StWait: begin
                    if (cnt_q == LastCnt) begin
                        state_q     <= StDone;
                        hreadyout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
`ifdef AHB_SRAM_ERR_EN
                StErr1: begin
                    state_q     <= StErr2;
                    hreadyout_q <= 1'b1;
                end
`endif
                // StIdle, StDone and StErr2: the bus is free for a new address phase.
                default: begin
                    if (accept) begin
                        addr_q      <= bus_io.HADDR[ADDR_W+1:2];
                        write_q     <= bus_io.HWRITE;
                        be_q        <= lane_mask(bus_io.HSIZE, bus_io.HADDR[1:0]);
                        cnt_q       <= '0;
                        hreadyout_q <= 1'b0;
`ifdef AHB_SRAM_ERR_EN
                        if (err_req) begin
                            state_q <= StErr1;
                            hresp_q <= HrespError;
                        end else begin
                            state_q <= StWait;
                            hresp_q <= HrespOkay;
                        end
`else
                        state_q     <= StWait;
`endif
                    end else begin
                        state_q     <= StIdle;
                        hreadyout_q <= 1'b1;
`ifdef AHB_SRAM_ERR_EN
                        hresp_q     <= HrespOkay;
`endif
                    end
                end
            endcase
        end
    end

    // Read fires on the last wait cycle so data lands exactly as HREADYOUT rises;
    // write commits in DONE, when HWDATA is guaranteed valid.
    always_comb begin
        mem_re = (state_q == StWait) && !write_q && (cnt_q == LastCnt);
        mem_we = ((state_q == StDone) && write_q) ? be_q : 4'b0000;
    end

    ahb_sram_mem #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (clk),
        .rst_i   (rst),
        .addr_i  (addr_q),
        .we_i    (mem_we),
        .wdata_i (bus_io.HWDATA),
        .re_i    (mem_re),
        .rdata_o (mem_rdata)
    );

    assign bus_io.HRDATA    = mem_rdata;
    assign bus_io.HREADYOUT = hreadyout_q;
`ifdef AHB_SRAM_ERR_EN
    assign bus_io.HRESP     = hresp_q;
`else
    assign bus_io.HRESP     = HrespOkay;
`endif

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: self-checking bench for ahb_sram_slave (single-slave system,
// HREADY looped back from HREADYOUT). Honours AHB_SRAM_ERR_EN for the error checks.
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    localparam int unsigned AW = 13;
    localparam int unsigned WS = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ahb_sram_slave_if bus();
    assign bus.HREADY = bus.HREADYOUT;

    ahb_sram_slave #(
        .ADDR_W      (AW),
        .WAIT_STATES (WS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] model [int];
    logic [31:0] exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.HSEL      = 1'b0;
        bus.HTRANS    = HtransIdle;
        bus.HWRITE    = 1'b0;
        bus.HADDR     = 32'h0;
        bus.HSIZE     = HsizeWord;
        bus.HMASTLOCK = 1'b0;
    endtask

    function automatic int word_idx(input logic [31:0] a);
        return int'((a >> 2) & ((32'd1 << AW) - 1));
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (model.exists(word_idx(a))) return model[word_idx(a)];
        return 'x;
    endfunction

    // Reference write: byte range is [lo, lo+nb) inside the word, lo rounded down to size.
    function automatic void model_write(input logic [31:0] a, input logic [1:0] s,
                                        input logic [31:0] d);
        int nb;
        int lo;
        logic [31:0] w;
        nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        lo = int'(a[1:0]);
        lo = lo - (lo % nb);
        w = model_read(a);
        for (int k = 0; k < nb; k++) begin
            w[8*(lo+k) +: 8] = d[8*(lo+k) +: 8];
        end
        model[word_idx(a)] = w;
    endfunction

    // Drive an address phase. For writes d is the write data (model updated);
    // for reads d is the expected read data (pushed to the scoreboard).
    task automatic addr_phase(input logic w, input logic [31:0] a, input logic [1:0] s,
                              input logic [31:0] d);
        bus.HSEL      = 1'b1;
        bus.HTRANS    = HtransNonseq;
        bus.HWRITE    = w;
        bus.HADDR     = a;
        bus.HSIZE     = s;
        bus.HMASTLOCK = 1'b0;
        if (w) model_write(a, s, d);
        else   exp_q.push_back(d);
    endtask

    // Called in the first data-phase cycle; returns in the cycle HREADYOUT is high.
    task automatic data_phase(input string name, input logic w, input logic [31:0] wdata);
        int n;
        logic [31:0] exp;
        bus.HWDATA = wdata;
        n = 1;
        while (bus.HREADYOUT !== 1'b1 && n <= 40) begin
            tick();
            n++;
        end
        tests_run++;
        if (n != WS + 1) begin
            tests_failed++;
            $display("FAIL %s_cycles: got %0d data-phase cycles, expected %0d", name, n, WS + 1);
        end
        tests_run++;
        if (bus.HRESP !== HrespOkay) begin
            tests_failed++;
            $display("FAIL %s_hresp: got %b expected %b", name, bus.HRESP, HrespOkay);
        end
        if (!w) begin
            exp = exp_q.pop_front();
            tests_run++;
            if (bus.HRDATA !== exp) begin
                tests_failed++;
                $display("FAIL %s_rdata: got %h expected %h", name, bus.HRDATA, exp);
            end
        end
    endtask

    task automatic xfer(input string name, input logic w, input logic [31:0] a,
                        input logic [1:0] s, input logic [31:0] d);
        addr_phase(w, a, s, d);
        tick();
        bus_idle();
        data_phase(name, w, d);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_idle();
        bus.HWDATA = 32'h0;
        repeat (3) tick();
        tests_run++;
        if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0 || bus.HRDATA !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got ready=%b resp=%b rdata=%h expected 1 0 00000000",
                     bus.HREADYOUT, bus.HRESP, bus.HRDATA);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        tests_run++;
        if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got ready=%b resp=%b expected 1 0",
                     bus.HREADYOUT, bus.HRESP);
        end
    endtask

    task automatic test_word();
        xfer("word_wr", 1'b1, 32'h0000_0010, HsizeWord, 32'hDEAD_BEEF);
        xfer("word_rd", 1'b0, 32'h0000_0010, HsizeWord, 32'hDEAD_BEEF);
    endtask

    task automatic test_byte_half();
        xfer("bh_init", 1'b1, 32'h0000_0010, HsizeWord, 32'h1122_3344);
        xfer("byte_wr", 1'b1, 32'h0000_0013, HsizeByte, 32'hAA00_0000);
        xfer("byte_rd", 1'b0, 32'h0000_0010, HsizeWord, 32'hAA22_3344);
        xfer("half_wr", 1'b1, 32'h0000_0010, HsizeHalf, 32'h0000_5566);
        xfer("half_rd", 1'b0, 32'h0000_0010, HsizeWord, 32'hAA22_5566);
        // Misaligned halfword at byte 3 must land on lanes 2 and 3.
        xfer("mhalf_wr", 1'b1, 32'h0000_0013, HsizeHalf, 32'h7788_0000);
        xfer("mhalf_rd", 1'b0, 32'h0000_0010, HsizeWord, 32'h7788_5566);
    endtask

    task automatic test_back_to_back();
        addr_phase(1'b1, 32'h0, HsizeWord, 32'hA5A5_5A5A);
        tick();
        bus_idle();
        data_phase("b2b_wr", 1'b1, 32'hA5A5_5A5A);
        addr_phase(1'b0, 32'h0, HsizeWord, 32'hA5A5_5A5A);
        tick();
        bus_idle();
        data_phase("b2b_rd", 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_reset_abort();
        xfer("abort_init", 1'b1, 32'h0000_0020, HsizeWord, 32'hCAFE_F00D);
        bus.HSEL   = 1'b1;
        bus.HTRANS = HtransNonseq;
        bus.HWRITE = 1'b1;
        bus.HADDR  = 32'h0000_0020;
        bus.HSIZE  = HsizeWord;
        tick();
        bus_idle();
        bus.HWDATA = 32'h1234_5678;
        tick();
        tests_run++;
        if (bus.HREADYOUT !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_inwait: got ready=%b expected 0", bus.HREADYOUT);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_ready: got ready=%b resp=%b expected 1 0",
                     bus.HREADYOUT, bus.HRESP);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        xfer("abort_rd", 1'b0, 32'h0000_0020, HsizeWord, 32'hCAFE_F00D);
    endtask

    task automatic test_idle();
        bus.HWRITE = 1'b1;
        bus.HADDR  = 32'h0000_0010;
        bus.HSIZE  = HsizeWord;
        bus.HWDATA = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            bus.HSEL   = (i != 2);
            bus.HTRANS = (i == 1) ? HtransBusy : (i == 2) ? HtransNonseq : HtransIdle;
            tick();
            tests_run++;
            if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle_%0d: got ready=%b resp=%b expected 1 0",
                         i, bus.HREADYOUT, bus.HRESP);
            end
        end
        bus_idle();
        tick();
        xfer("idle_rd", 1'b0, 32'h0000_0010, HsizeWord, 32'h7788_5566);
    endtask

`ifdef AHB_SRAM_ERR_EN
    task automatic err_seq(input string name, input logic w, input logic [31:0] a,
                           input logic [1:0] s);
        bus.HSEL   = 1'b1;
        bus.HTRANS = HtransNonseq;
        bus.HWRITE = w;
        bus.HADDR  = a;
        bus.HSIZE  = s;
        tick();
        bus_idle();
        bus.HWDATA = 32'h0BAD_0BAD;
        tests_run++;
        if (bus.HREADYOUT !== 1'b0 || bus.HRESP !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_err1: got ready=%b resp=%b expected 0 1",
                     name, bus.HREADYOUT, bus.HRESP);
        end
        tick();
        tests_run++;
        if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_err2: got ready=%b resp=%b expected 1 1",
                     name, bus.HREADYOUT, bus.HRESP);
        end
        tick();
        tests_run++;
        if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_after: got ready=%b resp=%b expected 1 0",
                     name, bus.HREADYOUT, bus.HRESP);
        end
    endtask

    task automatic test_range();
        err_seq("err_rd", 1'b0, 32'h0010_0000, HsizeWord);
        err_seq("err_wr_hi", 1'b1, 32'h0010_0000, HsizeWord);
        err_seq("err_wr_sz3", 1'b1, 32'h0000_0010, HsizeWide);
        xfer("err_chk0", 1'b0, 32'h0000_0000, HsizeWord, 32'hA5A5_5A5A);
        xfer("err_chk10", 1'b0, 32'h0000_0010, HsizeWord, 32'h7788_5566);
    endtask
`else
    task automatic test_range();
        xfer("alias_wr", 1'b1, 32'h0000_0000, HsizeWord, 32'h600D_CAFE);
        xfer("alias_rd", 1'b0, 32'h0010_0000, HsizeWord, 32'h600D_CAFE);
        xfer("sz3_wr", 1'b1, 32'h0000_0004, HsizeWide, 32'h0102_0304);
        xfer("sz3_rd", 1'b0, 32'h0000_0004, HsizeWord, 32'h0102_0304);
    endtask
`endif

    task automatic test_random();
        logic [31:0] a;
        logic [1:0] s;
        logic w;
        for (int i = 0; i < 8; i++) begin
            xfer("rnd_init", 1'b1, 32'h100 + 32'(i * 4), HsizeWord, $urandom);
        end
        for (int i = 0; i < 24; i++) begin
            w = 1'($urandom_range(0, 1));
            s = 2'($urandom_range(0, 2));
            a = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            if (w) xfer("rnd_wr", 1'b1, a, s, $urandom);
            else   xfer("rnd_rd", 1'b0, a, HsizeWord, model_read(a));
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_half();
        test_back_to_back();
        test_reset_abort();
        test_idle();
        test_range();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
